tie_status_rx: RTL

//  Receiving end of a core-to-core TIE wire: samples a producer core's TIE_status export every CLK,

---
 rtl/tie_status_rx_pkg.sv | 26 ++
 rtl/tie_status_rx_fifo.sv | 70 +++++++
 rtl/tie_status_rx.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/tie_status_rx_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tie_status_rx_pkg                                               |
// | Brief    : Shared defaults, FSM state type and event record for the       |
// |            TIE status receiver.                                            |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
package tie_status_rx_pkg;

    localparam int unsigned c_width = 50;
    localparam int unsigned c_ts_w  = 32;

    typedef enum logic [1:0] {
        OFF   = 2'd0,
        PRIME = 2'd1,
        RUN   = 2'd2
    } fsm_e;

    typedef struct packed {
        logic               first;
        logic [c_ts_w-1:0]  ts;
        logic [c_width-1:0] data;
    } event_t;

endpackage
`default_nettype wire

// File: rtl/tie_status_rx_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tie_status_rx_fifo                                              |
// | Brief    : Synchronous DEPTH-entry event FIFO; a push while full is only  |
// |            accepted when a pop frees the head slot on the same edge.       |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module tie_status_rx_fifo
    import tie_status_rx_pkg::*;
#(
    parameter int unsigned DEPTH   = 4,
    parameter type         T_ENTRY = event_t
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_push,
    input  T_ENTRY                   i_data,
    input  logic                     i_pop,
    output T_ENTRY                   o_data,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_level
);

    localparam int unsigned     c_aw   = $clog2(DEPTH);
    localparam logic [c_aw:0]   c_full = (c_aw+1)'(DEPTH);

    T_ENTRY          r_mem [DEPTH];
    logic [c_aw-1:0] r_wptr;
    logic [c_aw-1:0] r_rptr;
    logic [c_aw:0]   r_level;
    logic            w_push;
    logic            w_pop;

    assign o_full  = (r_level == c_full);
    assign o_empty = (r_level == '0);
    assign o_level = r_level;
    assign o_data  = r_mem[r_rptr];

    assign w_pop  = i_pop && !o_empty;
    assign w_push = i_push && (!o_full || w_pop);

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= i_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_level <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + c_aw'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + c_aw'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + (c_aw+1)'(1);
                2'b01:   r_level <= r_level - (c_aw+1)'(1);
                default: r_level <= r_level;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/tie_status_rx.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tie_status_rx                                                   |
// | Brief    : Samples a producer TIE_status wire, queues change events with   |
// |            optional timestamps, counts drops. Macro TIE_STATUS_RX_TS_EN    |
// |            enables the timestamp counter.                                  |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module tie_status_rx
    import tie_status_rx_pkg::*;
#(
    parameter int unsigned WIDTH  = c_width,
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned TS_W   = c_ts_w,
    parameter int unsigned DROP_W = 8
) (
    input  logic                     CLK,
    input  logic                     BReset_N,
    input  logic [WIDTH-1:0]         TIE_status,
    input  logic                     en,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [WIDTH-1:0]         out_data,
    output logic [TS_W-1:0]          out_ts,
    output logic                     out_first,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     ovf,
    output logic [DROP_W-1:0]        drop_cnt,
    input  logic                     ovf_clr
);

`ifdef TIE_STATUS_RX_TS_EN
    typedef struct packed {
        logic             first;
        logic [TS_W-1:0]  ts;
        logic [WIDTH-1:0] data;
    } entry_t;
`else
    typedef struct packed {
        logic             first;
        logic [WIDTH-1:0] data;
    } entry_t;
`endif

    fsm_e              r_state;
    fsm_e              w_state_nxt;
    logic [WIDTH-1:0]  r_sq;
    logic [WIDTH-1:0]  r_last;
    logic              r_ovf;
    logic [DROP_W-1:0] r_drop_cnt;
    logic              w_rst;
    logic              w_push_req;
    logic              w_first;
    logic              w_pop;
    logic              w_full;
    logic              w_empty;
    logic              w_drop;
    entry_t            w_wr;
    entry_t            w_rd;

    assign w_rst = !BReset_N;

    always_ff @(posedge CLK) begin
        if (!BReset_N) begin
            r_state <= OFF;
            r_sq    <= '0;
            r_last  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_sq    <= TIE_status;
            if (r_state != OFF) begin
                r_last <= r_sq;
            end
        end
    end

    // PRIME snapshots unconditionally; RUN only reports changes against the last sample.
    always_comb begin
        w_state_nxt = r_state;
        w_push_req  = 1'b0;
        w_first     = 1'b0;
        case (r_state)
            OFF: begin
                if (en) w_state_nxt = PRIME;
            end
            PRIME: begin
                w_push_req  = 1'b1;
                w_first     = 1'b1;
                w_state_nxt = RUN;
            end
            RUN: begin
                w_push_req = (r_sq != r_last);
            end
            default: w_state_nxt = OFF;
        endcase
        if (!en) w_state_nxt = OFF;
    end

`ifdef TIE_STATUS_RX_TS_EN
    logic [TS_W-1:0] r_ts;

    always_ff @(posedge CLK) begin
        if (!BReset_N) begin
            r_ts <= '0;
        end else begin
            r_ts <= r_ts + TS_W'(1);
        end
    end

    assign w_wr   = {w_first, r_ts, r_sq};
    assign out_ts = w_empty ? '0 : w_rd.ts;
`else
    assign w_wr   = {w_first, r_sq};
    assign out_ts = '0;
`endif

    tie_status_rx_fifo #(
        .DEPTH   (DEPTH),
        .T_ENTRY (entry_t)
    ) u_fifo (
        .clk     (CLK),
        .rst     (w_rst),
        .i_push  (w_push_req),
        .i_data  (w_wr),
        .i_pop   (out_ready),
        .o_data  (w_rd),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_level (level)
    );

    assign w_pop  = out_ready && !w_empty;
    assign w_drop = w_push_req && w_full && !w_pop;

    // A drop outranks a coincident clear so the lost event is never hidden.
    always_ff @(posedge CLK) begin
        if (!BReset_N) begin
            r_ovf      <= 1'b0;
            r_drop_cnt <= '0;
        end else if (w_drop) begin
            r_ovf <= 1'b1;
            if (ovf_clr) begin
                r_drop_cnt <= DROP_W'(1);
            end else if (!(&r_drop_cnt)) begin
                r_drop_cnt <= r_drop_cnt + DROP_W'(1);
            end
        end else if (ovf_clr) begin
            r_ovf      <= 1'b0;
            r_drop_cnt <= '0;
        end
    end

    assign out_valid = !w_empty;
    assign out_data  = w_empty ? '0 : w_rd.data;
    assign out_first = !w_empty && w_rd.first;
    assign ovf       = r_ovf;
    assign drop_cnt  = r_drop_cnt;

endmodule
`default_nettype wire
